uart_transmitter: RTL and testbench



---
 rtl/uart_transmitter.sv | 170 +++++++++++++++++
 tb/tb_uart_transmitter.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_transmitter.sv
// UART transmitter: small byte FIFO feeding an 8N1 serializer on line x.
// Define TX_PARITY_EN to insert an even-parity bit between data and stop.
module uart_transmitter #(
  parameter int CLKS_PER_BIT = 1,
  parameter int DATA_WIDTH   = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  rdy,
  output logic                  busy,
  output logic                  x
);

  localparam int BW = $clog2(CLKS_PER_BIT) + 1;
  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DATA_WIDTH - 1);
  localparam logic [CW-1:0] CNT_FULL  = CW'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

  state_t                state;
  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr;
  logic [PW-1:0]         rd_ptr;
  logic [CW-1:0]         count;
  logic [DATA_WIDTH-1:0] shift;
  logic [DATA_WIDTH-1:0] head;
  logic [BW-1:0]         baud;
  logic [IW-1:0]         bit_idx;
  logic                  baud_end;
  logic                  push;
  logic                  pop;
`ifdef TX_PARITY_EN
  logic                  parity;
`endif

  assign rdy      = (count < CNT_FULL);
  assign busy     = (state != IDLE) || (count != '0);
  assign push     = en && rdy;
  assign head     = mem[rd_ptr];
  assign baud_end = (baud == BAUD_LAST);
  // Pop only when the line is free: idle, or the last stop cycle.
  assign pop      = (count != '0) &&
                    ((state == IDLE) || ((state == STOP) && baud_end));

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      count <= count + 1'b1;
      else if (pop && !push) count <= count - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      x       <= 1'b1;
      baud    <= '0;
      bit_idx <= '0;
      shift   <= '0;
`ifdef TX_PARITY_EN
      parity  <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          x    <= 1'b1;
          baud <= '0;
          if (pop) begin
            shift  <= head;
`ifdef TX_PARITY_EN
            parity <= ^head;
`endif
            x      <= 1'b0;
            state  <= START;
          end
        end
        START: begin
          if (baud_end) begin
            baud    <= '0;
            x       <= shift[0];
            shift   <= shift >> 1;
            bit_idx <= '0;
            state   <= DATA;
          end else begin
            baud <= baud + 1'b1;
          end
        end
        DATA: begin
          if (baud_end) begin
            baud <= '0;
            if (bit_idx == IDX_LAST) begin
`ifdef TX_PARITY_EN
              x     <= parity;
              state <= PARITY;
`else
              x     <= 1'b1;
              state <= STOP;
`endif
            end else begin
              x       <= shift[0];
              shift   <= shift >> 1;
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
`ifdef TX_PARITY_EN
        PARITY: begin
          if (baud_end) begin
            baud  <= '0;
            x     <= 1'b1;
            state <= STOP;
          end else begin
            baud <= baud + 1'b1;
          end
        end
`endif
        STOP: begin
          if (baud_end) begin
            baud <= '0;
            // Back-to-back frames: go straight to the next start bit.
            if (pop) begin
              shift  <= head;
`ifdef TX_PARITY_EN
              parity <= ^head;
`endif
              x      <= 1'b0;
              state  <= START;
            end else begin
              state <= IDLE;
            end
          end else begin
            baud <= baud + 1'b1;
          end
        end
        default: begin
          x     <= 1'b1;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_transmitter.sv
// Bench for uart_transmitter: bit-stream queue model, CLKS_PER_BIT 1 and 4.
module tb_uart_transmitter;

  localparam int DW    = 8;
  localparam int DEPTH = 4;
`ifdef TX_PARITY_EN
  localparam int FBITS = DW + 3;
  localparam logic [FBITS-1:0] EXP_1C = 11'h638;
  localparam logic [FBITS-1:0] EXP_0F = 11'h41E;
  localparam int ZEROS_55 = 24;
`else
  localparam int FBITS = DW + 2;
  localparam logic [FBITS-1:0] EXP_1C = 10'h238;
  localparam logic [FBITS-1:0] EXP_0F = 10'h21E;
  localparam int ZEROS_55 = 20;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          en1, en4;
  logic [DW-1:0] data1, data4;
  logic          rdy1, busy1, x1;
  logic          rdy4, busy4, x4;

  always #5 clk = ~clk;

  uart_transmitter #(
    .CLKS_PER_BIT(1), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut1 (
    .clk(clk), .rst_n(rst_n), .en(en1), .data(data1),
    .rdy(rdy1), .busy(busy1), .x(x1)
  );

  uart_transmitter #(
    .CLKS_PER_BIT(4), .DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)
  ) dut4 (
    .clk(clk), .rst_n(rst_n), .en(en4), .data(data4),
    .rdy(rdy4), .busy(busy4), .x(x4)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [DW-1:0] fq1[$], fq4[$];
  logic          wq1[$], wq4[$];
  logic [2:0]    exp1, exp4;

  // Model: accepted bytes queue plus queue of future line values.
  task automatic model_edge(input int sel, input logic e,
                            input logic [DW-1:0] d,
                            output logic [2:0] ex);
    logic [DW-1:0] f[$];
    logic          w[$];
    logic [DW-1:0] b;
    logic          xv;
    logic          used;
    int            cpb;
    int            pre_n;
    if (sel == 0) begin
      f = fq1; w = wq1; cpb = 1;
    end else begin
      f = fq4; w = wq4; cpb = 4;
    end
    pre_n = f.size();
    used  = 1'b0;
    if (w.size() == 0 && f.size() != 0) begin
      b = f.pop_front();
      for (int r = 0; r < cpb; r++) w.push_back(1'b0);
      for (int i = 0; i < DW; i++)
        for (int r = 0; r < cpb; r++) w.push_back(b[i]);
`ifdef TX_PARITY_EN
      for (int r = 0; r < cpb; r++) w.push_back(^b);
`endif
      for (int r = 0; r < cpb; r++) w.push_back(1'b1);
    end
    if (e && pre_n < DEPTH) f.push_back(d);
    if (w.size() != 0) begin
      xv   = w.pop_front();
      used = 1'b1;
    end else begin
      xv = 1'b1;
    end
    ex = {xv, f.size() < DEPTH, used || f.size() != 0};
    if (sel == 0) begin
      fq1 = f; wq1 = w;
    end else begin
      fq4 = f; wq4 = w;
    end
  endtask

  task automatic clear_model();
    fq1.delete(); wq1.delete();
    fq4.delete(); wq4.delete();
  endtask

  task automatic step(input logic e1, input logic [DW-1:0] d1,
                      input logic e4, input logic [DW-1:0] d4);
    en1 = e1; data1 = d1;
    en4 = e4; data4 = d4;
    @(posedge clk);
    #1;
    model_edge(0, e1, d1, exp1);
    model_edge(1, e4, d4, exp4);
  endtask

  task automatic test_reset();
    en1 = 0; en4 = 0; data1 = '0; data4 = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if ({x1, rdy1, busy1} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset dut1 x/rdy/busy=%b want 110", {x1, rdy1, busy1});
    end
    n_tests++;
    if ({x4, rdy4, busy4} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset dut4 x/rdy/busy=%b want 110", {x4, rdy4, busy4});
    end
    @(negedge clk);
    rst_n = 1'b1;
    clear_model();
    step(1'b1, 8'hAA, 1'b1, 8'h3C);
    for (int i = 0; i < 4; i++) begin
      n_tests++;
      if ({x1, rdy1, busy1} !== exp1) begin
        n_fail++;
        $display("FAIL pre_async dut1 got %b want %b", {x1, rdy1, busy1}, exp1);
      end
      n_tests++;
      if ({x4, rdy4, busy4} !== exp4) begin
        n_fail++;
        $display("FAIL pre_async dut4 got %b want %b", {x4, rdy4, busy4}, exp4);
      end
      step(1'b0, '0, 1'b0, '0);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({x1, rdy1, busy1, x4, rdy4, busy4} !== 6'b110110) begin
      n_fail++;
      $display("FAIL async_reset got %b want 110110",
               {x1, rdy1, busy1, x4, rdy4, busy4});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    clear_model();
  endtask

  task automatic test_single();
    logic [FBITS-1:0] cap;
    cap = '0;
    step(1'b1, 8'h1C, 1'b0, '0);
    for (int i = 0; i < FBITS + 3; i++) begin
      step(1'b0, '0, 1'b0, '0);
      if (i < FBITS) cap[i] = x1;
      n_tests++;
      if ({x1, rdy1, busy1} !== exp1) begin
        n_fail++;
        $display("FAIL single cyc%0d got %b want %b", i, {x1, rdy1, busy1}, exp1);
      end
    end
    n_tests++;
    if (cap !== EXP_1C) begin
      n_fail++;
      $display("FAIL single_frame got %b want %b", cap, EXP_1C);
    end
  endtask

  task automatic test_fill();
    logic [DW-1:0] bytes [6];
    int busy_cycles;
    bytes = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};
    busy_cycles = 0;
    for (int i = 0; i < 5 * FBITS + 12; i++) begin
      if (i < 6) step(1'b1, bytes[i], 1'b0, '0);
      else       step(1'b0, '0, 1'b0, '0);
      busy_cycles += int'(busy1);
      n_tests++;
      if ({x1, rdy1, busy1} !== exp1) begin
        n_fail++;
        $display("FAIL fill cyc%0d got %b want %b", i, {x1, rdy1, busy1}, exp1);
      end
    end
    n_tests++;
    if (busy_cycles !== 1 + 5 * FBITS) begin
      n_fail++;
      $display("FAIL fill_busy got %0d want %0d", busy_cycles, 1 + 5 * FBITS);
    end
  endtask

  task automatic test_baud4();
    int zeros;
    zeros = 0;
    step(1'b0, '0, 1'b1, 8'h55);
    for (int i = 0; i < 4 * FBITS + 6; i++) begin
      step(1'b0, '0, 1'b0, '0);
      zeros += int'(!x4);
      n_tests++;
      if ({x4, rdy4, busy4} !== exp4) begin
        n_fail++;
        $display("FAIL baud4 cyc%0d got %b want %b", i, {x4, rdy4, busy4}, exp4);
      end
    end
    n_tests++;
    if (zeros !== ZEROS_55) begin
      n_fail++;
      $display("FAIL baud4_zeros got %0d want %0d", zeros, ZEROS_55);
    end
  endtask

  task automatic test_mid_reset();
    logic [FBITS-1:0] cap;
    step(1'b1, 8'hF0, 1'b0, '0);
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b0, '0);
    n_tests++;
    if ({x1, rdy1, busy1} !== exp1) begin
      n_fail++;
      $display("FAIL mid_bit3 got %b want %b", {x1, rdy1, busy1}, exp1);
    end
    #2 rst_n = 1'b0;
    #1;
    n_tests++;
    if ({x1, rdy1, busy1} !== 3'b110) begin
      n_fail++;
      $display("FAIL mid_reset got %b want 110", {x1, rdy1, busy1});
    end
    @(posedge clk);
    #3 rst_n = 1'b1;
    clear_model();
    cap = '0;
    step(1'b1, 8'h0F, 1'b0, '0);
    for (int i = 0; i < FBITS + 3; i++) begin
      step(1'b0, '0, 1'b0, '0);
      if (i < FBITS) cap[i] = x1;
      n_tests++;
      if ({x1, rdy1, busy1} !== exp1) begin
        n_fail++;
        $display("FAIL post_reset cyc%0d got %b want %b", i, {x1, rdy1, busy1}, exp1);
      end
    end
    n_tests++;
    if (cap !== EXP_0F) begin
      n_fail++;
      $display("FAIL post_reset_frame got %b want %b", cap, EXP_0F);
    end
  endtask

`ifdef TX_PARITY_EN
  task automatic test_parity();
    logic [DW-1:0] bv [2];
    logic [FBITS-1:0] cap;
    bv = '{8'h1C, 8'h03};
    for (int k = 0; k < 2; k++) begin
      cap = '0;
      step(1'b1, bv[k], 1'b0, '0);
      for (int i = 0; i < FBITS + 1; i++) begin
        step(1'b0, '0, 1'b0, '0);
        if (i < FBITS) cap[i] = x1;
      end
      n_tests++;
      if (cap[DW+1] !== (k == 0)) begin
        n_fail++;
        $display("FAIL parity byte%0d got %b want %b", k, cap[DW+1], k == 0);
      end
    end
  endtask
`endif

  task automatic test_random();
    logic e1, e4;
    for (int i = 0; i < 600; i++) begin
      e1 = ($urandom_range(0, 3) == 0);
      e4 = ($urandom_range(0, 15) == 0);
      step(e1, DW'($urandom), e4, DW'($urandom));
      n_tests++;
      if ({x1, rdy1, busy1} !== exp1) begin
        n_fail++;
        $display("FAIL rand1 cyc%0d got %b want %b", i, {x1, rdy1, busy1}, exp1);
      end
      n_tests++;
      if ({x4, rdy4, busy4} !== exp4) begin
        n_fail++;
        $display("FAIL rand4 cyc%0d got %b want %b", i, {x4, rdy4, busy4}, exp4);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_fill();
    test_baud4();
    test_mid_reset();
`ifdef TX_PARITY_EN
    test_parity();
`endif
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
